// File: rtl/dnn_run_cycle_counter.sv
// Free-running cycle counter that timestamps accelerator runs between an accepted
// start and the matching done, and reports per-run length and a completed-run tally.
module dnn_run_cycle_counter #(
  parameter int CNT_W     = 64,
  parameter int RUN_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 increment,
  input  logic                 start,
  input  logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic [CNT_W-1:0]     start_cycle,
  output logic [CNT_W-1:0]     end_cycle,
  output logic [CNT_W-1:0]     total_cycles,
  output logic                 done_pulse,
  output logic [RUN_CNT_W-1:0] run_count,
  output logic                 wrapped
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wrapped_q, wrapped_d;
  logic [CNT_W-1:0]     startCycle_q, startCycle_d;
  logic [CNT_W-1:0]     endCycle_q, endCycle_d;
  logic [CNT_W-1:0]     totalCycles_q, totalCycles_d;
  logic [RUN_CNT_W-1:0] runCount_q, runCount_d;
  logic                 donePulse_q, donePulse_d;

  // The counter free-runs regardless of FSM state; wrap is detected on the all-ones value.
  always_comb begin
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (increment) begin
      count_d   = count_q + CNT_W'(1);
      wrapped_d = wrapped_q | (&count_q);
    end
  end

  // Captures use the pre-increment count of the accepting cycle, so subtraction
  // modulo 2^CNT_W gives the right length even across a wrap.
  always_comb begin
    state_d       = state_q;
    startCycle_d  = startCycle_q;
    endCycle_d    = endCycle_q;
    totalCycles_d = totalCycles_q;
    runCount_d    = runCount_q;
    donePulse_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          startCycle_d = count_q;
        end
      end
      RUN: begin
        if (done) begin
          state_d       = IDLE;
          endCycle_d    = count_q;
          totalCycles_d = count_q - startCycle_q;
          runCount_d    = runCount_q + RUN_CNT_W'(1);
          donePulse_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      wrapped_q     <= 1'b0;
      startCycle_q  <= '0;
      endCycle_q    <= '0;
      totalCycles_q <= '0;
      runCount_q    <= '0;
      donePulse_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wrapped_q     <= wrapped_d;
      startCycle_q  <= startCycle_d;
      endCycle_q    <= endCycle_d;
      totalCycles_q <= totalCycles_d;
      runCount_q    <= runCount_d;
      donePulse_q   <= donePulse_d;
    end
  end

  assign count        = count_q;
  assign busy         = (state_q == RUN);
  assign start_cycle  = startCycle_q;
  assign end_cycle    = endCycle_q;
  assign total_cycles = totalCycles_q;
  assign done_pulse   = donePulse_q;
  assign run_count    = runCount_q;
  assign wrapped      = wrapped_q;

endmodule

// File: tb/tb_dnn_run_cycle_counter.sv
// Scoreboard bench for dnn_run_cycle_counter: a full-width instance for run timing and
// a 4-bit instance to reach counter wrap and run-count wrap quickly.
module tb_dnn_run_cycle_counter;

  logic clk;
  logic rst;

  logic        increment, start, done;
  logic [63:0] count, startCycle, endCycle, totalCycles;
  logic        busy, donePulse, wrapped;
  logic [15:0] runCount;

  logic       sIncrement, sStart, sDone;
  logic [3:0] sCount, sStartCycle, sEndCycle, sTotalCycles;
  logic       sBusy, sDonePulse, sWrapped;
  logic [1:0] sRunCount;

  int total;
  int bad;

  typedef struct {
    logic [63:0] startCycle;
    logic [63:0] endCycle;
    logic [63:0] totalCycles;
    logic [15:0] runCount;
  } exp_t;

  exp_t expQ[$];
  logic prevPulse;

  dnn_run_cycle_counter #(.CNT_W(64), .RUN_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .increment(increment), .start(start), .done(done),
    .count(count), .busy(busy), .start_cycle(startCycle), .end_cycle(endCycle),
    .total_cycles(totalCycles), .done_pulse(donePulse), .run_count(runCount),
    .wrapped(wrapped)
  );

  dnn_run_cycle_counter #(.CNT_W(4), .RUN_CNT_W(2)) dutSmall (
    .clk(clk), .rst(rst), .increment(sIncrement), .start(sStart), .done(sDone),
    .count(sCount), .busy(sBusy), .start_cycle(sStartCycle), .end_cycle(sEndCycle),
    .total_cycles(sTotalCycles), .done_pulse(sDonePulse), .run_count(sRunCount),
    .wrapped(sWrapped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Outputs are sampled at the falling edge; every pulse must match a queued run.
  always @(negedge clk) begin
    if (!rst && donePulse) begin
      if (prevPulse) checkOutput("pulse_width", 64'd2, 64'd1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sb_start_cycle", startCycle, e.startCycle);
        checkOutput("sb_end_cycle", endCycle, e.endCycle);
        checkOutput("sb_total_cycles", totalCycles, e.totalCycles);
        checkOutput("sb_run_count", 64'(runCount), 64'(e.runCount));
        checkOutput("sb_busy_at_pulse", 64'(busy), 64'd0);
      end
    end
    prevPulse <= donePulse;
  end

  task automatic goTo(input logic [63:0] target);
    int n;
    n = 0;
    while (count !== target && n < 300) begin
      step(1);
      n++;
    end
    if (count !== target) checkOutput("goto_timeout", count, target);
  endtask

  task automatic goToSmall(input logic [3:0] target);
    int n;
    n = 0;
    while (sCount !== target && n < 40) begin
      step(1);
      n++;
    end
    if (sCount !== target) checkOutput("goto_small_timeout", 64'(sCount), 64'(target));
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d);
    rst   = r;
    start = s;
    done  = d;
  endtask

  task automatic pushExp(input logic [63:0] s, input logic [63:0] e, input logic [63:0] t, input logic [15:0] r);
    exp_t x;
    x.startCycle  = s;
    x.endCycle    = e;
    x.totalCycles = t;
    x.runCount    = r;
    expQ.push_back(x);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    prevPulse = 1'b0;
    increment = 1'b1;
    sIncrement = 1'b1;
    sStart = 1'b0;
    sDone = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Reset state, then ten counting cycles
    step(2);
    checkOutput("reset_count", count, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_run_count", 64'(runCount), 64'd0);
    checkOutput("reset_wrapped", 64'(wrapped), 64'd0);
    rst = 1'b0;
    step(10);
    checkOutput("count_after_10", count, 64'd10);
    checkOutput("total_idle", totalCycles, 64'd0);
    checkOutput("done_pulse_idle", 64'(donePulse), 64'd0);

    // Single run: start at 5, done at 25
    doReset();
    goTo(64'd5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checkOutput("run1_busy", 64'(busy), 64'd1);
    checkOutput("run1_start_cycle", startCycle, 64'd5);
    goTo(64'd25);
    done = 1'b1;
    pushExp(64'd5, 64'd25, 64'd20, 16'd1);
    step(1);
    done = 1'b0;
    step(1);
    checkOutput("run1_pulse_gone", 64'(donePulse), 64'd0);

    // Level-held start, then back-to-back run with start still high
    doReset();
    goTo(64'd3);
    start = 1'b1;
    step(4);
    start = 1'b0;
    checkOutput("held_start_cycle", startCycle, 64'd3);
    checkOutput("held_busy", 64'(busy), 64'd1);
    goTo(64'd9);
    applyStimulus(1'b0, 1'b1, 1'b1);
    pushExp(64'd3, 64'd9, 64'd6, 16'd1);
    step(1);
    done = 1'b0;
    checkOutput("held_idle_busy", 64'(busy), 64'd0);
    step(1);
    start = 1'b0;
    checkOutput("rerun_busy", 64'(busy), 64'd1);
    checkOutput("rerun_start_cycle", startCycle, 64'd10);
    checkOutput("rerun_prev_total", totalCycles, 64'd6);
    goTo(64'd15);
    done = 1'b1;
    pushExp(64'd10, 64'd15, 64'd5, 16'd2);
    step(1);
    done = 1'b0;

    // done while idle changes nothing
    step(1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    checkOutput("idle_done_pulse_a", 64'(donePulse), 64'd0);
    step(1);
    checkOutput("idle_done_pulse_b", 64'(donePulse), 64'd0);
    checkOutput("idle_done_end", endCycle, 64'd15);
    checkOutput("idle_done_total", totalCycles, 64'd5);
    checkOutput("idle_done_runs", 64'(runCount), 64'd2);

    // start and done together in IDLE: start wins
    goTo(64'd20);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("simul_busy", 64'(busy), 64'd1);
    checkOutput("simul_start_cycle", startCycle, 64'd20);
    checkOutput("simul_runs", 64'(runCount), 64'd2);
    goTo(64'd23);
    done = 1'b1;
    pushExp(64'd20, 64'd23, 64'd3, 16'd3);
    step(1);
    done = 1'b0;

    // increment low holds the count
    increment = 1'b0;
    step(3);
    checkOutput("hold_count", count, 64'd24);
    increment = 1'b1;
    step(1);
    checkOutput("resume_count", count, 64'd25);

    // Reset in the middle of a run
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    checkOutput("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("midrun_rst_busy", 64'(busy), 64'd0);
    checkOutput("midrun_rst_count", count, 64'd0);
    checkOutput("midrun_rst_runs", 64'(runCount), 64'd0);
    checkOutput("midrun_rst_start", startCycle, 64'd0);
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(1);
    checkOutput("late_done_runs", 64'(runCount), 64'd0);
    checkOutput("late_done_end", endCycle, 64'd0);
    checkOutput("late_done_pulse", 64'(donePulse), 64'd0);

    // Counter wrap on the 4-bit instance: start at 14, done at 3
    doReset();
    checkOutput("small_reset_wrapped", 64'(sWrapped), 64'd0);
    goToSmall(4'd14);
    sStart = 1'b1;
    step(1);
    sStart = 1'b0;
    goToSmall(4'd3);
    sDone = 1'b1;
    step(1);
    sDone = 1'b0;
    checkOutput("wrap_total", 64'(sTotalCycles), 64'd5);
    checkOutput("wrap_end", 64'(sEndCycle), 64'd3);
    checkOutput("wrap_start", 64'(sStartCycle), 64'd14);
    checkOutput("wrap_flag", 64'(sWrapped), 64'd1);
    checkOutput("wrap_pulse", 64'(sDonePulse), 64'd1);
    checkOutput("wrap_runs", 64'(sRunCount), 64'd1);

    // Three one-cycle runs push the 2-bit run counter from 1 around to 0
    for (int i = 0; i < 3; i++) begin
      sStart = 1'b1;
      step(1);
      sStart = 1'b0;
      sDone = 1'b1;
      step(1);
      sDone = 1'b0;
    end
    checkOutput("runcount_wrap", 64'(sRunCount), 64'd0);
    checkOutput("short_run_total", 64'(sTotalCycles), 64'd1);

    step(2);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
